// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the memory-port controller.
// Holds the FSM state, access owner and latency counter width.
package mem_access_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      INSTR = 1'b0,
      DATA  = 1'b1
   } owner_t;

   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_access_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter (instruction vs data).
// Ports: req_instr/req_data in, grant_stb in (commit grant),
//        valid out (any request), grant out (chosen owner).
module mem_access_ctrl_rr_arb2
   import mem_access_ctrl_pkg::*;
(
   input  logic   clock,
   input  logic   reset,
   input  logic   req_instr,
   input  logic   req_data,
   input  logic   grant_stb,
   output logic   valid,
   output owner_t grant
);

   owner_t last;

   // On a tie the requester opposite the last grant wins.
   always_comb begin
      valid = req_instr | req_data;
      grant = INSTR;
      if (req_data && (!req_instr || last == INSTR))
         grant = DATA;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         last <= INSTR;
      else if (grant_stb)
         last <= grant;
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates one single-port memory between fetch and data-cache
// traffic, sequences each access, refills the data cache and
// stalls the pipeline while a requester waits.
// Ports: i_* fetch side, d_* data side, mem_* memory port,
//        fill_* cache write, stall to the pipeline.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int MEM_LAT = 3,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              fill_en,
   output logic [ADDR_W-1:0] fill_addr,
   output logic [DATA_W-1:0] fill_data
);

   localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT - 1);

   state_t            state;
   state_t            state_n;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_n;
   owner_t            owner;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;
   logic              grant_stb;
   logic              arb_valid;
   owner_t            arb_grant;
   logic              done;

   mem_access_ctrl_rr_arb2 u_arb (
      .clock     (clock),
      .reset     (reset),
      .req_instr (i_req),
      .req_data  (d_req),
      .grant_stb (grant_stb),
      .valid     (arb_valid),
      .grant     (arb_grant)
   );

   assign done = (state == ACCESS) && (cnt == '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         owner   <= INSTR;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         i_rdata <= '0;
         d_rdata <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (grant_stb) begin
            owner <= arb_grant;
            if (arb_grant == DATA) begin
               addr_q  <= d_addr;
               wdata_q <= d_wdata;
               we_q    <= d_we;
            end else begin
               addr_q  <= i_addr;
               wdata_q <= '0;
               we_q    <= 1'b0;
            end
         end
         // A store reports its own data back as the loaded word.
         if (done) begin
            if (owner == INSTR)
               i_rdata <= mem_rdata;
            else
               d_rdata <= we_q ? wdata_q : mem_rdata;
         end
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      grant_stb = 1'b0;
      unique case (state)
         IDLE: begin
            if (arb_valid) begin
               grant_stb = 1'b1;
               state_n   = ACCESS;
               cnt_n     = LAT_INIT;
            end
         end
         ACCESS: begin
            if (cnt == '0)
               state_n = RESP;
            else
               cnt_n = cnt - CNT_W'(1);
         end
         RESP: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      i_ready   = 1'b0;
      d_ready   = 1'b0;
      fill_en   = 1'b0;
      fill_addr = '0;
      fill_data = '0;
      if (state == ACCESS) begin
         mem_en    = 1'b1;
         mem_we    = we_q;
         mem_addr  = addr_q;
         mem_wdata = wdata_q;
      end
      if (state == RESP) begin
         if (owner == INSTR) begin
            i_ready = 1'b1;
         end else begin
            d_ready   = 1'b1;
            fill_en   = 1'b1;
            fill_addr = addr_q;
            fill_data = d_rdata;
         end
      end
   end

   assign stall = (i_req & ~i_ready) | (d_req & ~d_ready);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: MEM_LAT=3 instance (a)
// and MEM_LAT=1 instance (b) sharing clock and reset.
module tb_mem_access_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   int          total = 0;
   int          bad   = 0;

   logic        i_req_a = 0, d_req_a = 0, d_we_a = 0;
   logic [15:0] i_addr_a = 0, d_addr_a = 0, d_wdata_a = 0;
   logic [15:0] mem_rdata_a = 0;
   logic [15:0] i_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a;
   logic [15:0] fill_addr_a, fill_data_a;
   logic        i_ready_a, d_ready_a, stall_a, mem_en_a, mem_we_a;
   logic        fill_en_a;

   logic        i_req_b = 0, d_req_b = 0, d_we_b = 0;
   logic [15:0] i_addr_b = 0, d_addr_b = 0, d_wdata_b = 0;
   logic [15:0] mem_rdata_b = 0;
   logic [15:0] i_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b;
   logic [15:0] fill_addr_b, fill_data_b;
   logic        i_ready_b, d_ready_b, stall_b, mem_en_b, mem_we_b;
   logic        fill_en_b;

   always #5 clock = ~clock;

   mem_access_ctrl #(.MEM_LAT(3)) dut_a (
      .clock(clock), .reset(reset),
      .i_req(i_req_a), .i_addr(i_addr_a),
      .i_rdata(i_rdata_a), .i_ready(i_ready_a),
      .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a),
      .d_wdata(d_wdata_a), .d_rdata(d_rdata_a),
      .d_ready(d_ready_a), .stall(stall_a),
      .mem_en(mem_en_a), .mem_we(mem_we_a),
      .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
      .mem_rdata(mem_rdata_a), .fill_en(fill_en_a),
      .fill_addr(fill_addr_a), .fill_data(fill_data_a)
   );

   mem_access_ctrl #(.MEM_LAT(1)) dut_b (
      .clock(clock), .reset(reset),
      .i_req(i_req_b), .i_addr(i_addr_b),
      .i_rdata(i_rdata_b), .i_ready(i_ready_b),
      .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b),
      .d_wdata(d_wdata_b), .d_rdata(d_rdata_b),
      .d_ready(d_ready_b), .stall(stall_b),
      .mem_en(mem_en_b), .mem_we(mem_we_b),
      .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .mem_rdata(mem_rdata_b), .fill_en(fill_en_b),
      .fill_addr(fill_addr_b), .fill_data(fill_data_b)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset state
      tick();
      tick();
      chk("rst_mem_en", 16'(mem_en_a), 16'h0);
      chk("rst_i_ready", 16'(i_ready_a), 16'h0);
      chk("rst_d_ready", 16'(d_ready_a), 16'h0);
      chk("rst_fill_en", 16'(fill_en_a), 16'h0);
      chk("rst_stall", 16'(stall_a), 16'h0);
      chk("rst_i_rdata", i_rdata_a, 16'h0);
      chk("rst_d_rdata", d_rdata_a, 16'h0);
      reset = 1'b0;
      tick();

      // fetch, MEM_LAT=3
      i_req_a = 1; i_addr_a = 16'h0010; mem_rdata_a = 16'hABCD;
      #1;
      chk("f_c0_stall", 16'(stall_a), 16'h1);
      chk("f_c0_mem_en", 16'(mem_en_a), 16'h0);
      for (int c = 1; c <= 3; c++) begin
         tick();
         chk("f_mem_en", 16'(mem_en_a), 16'h1);
         chk("f_mem_addr", mem_addr_a, 16'h0010);
         chk("f_mem_we", 16'(mem_we_a), 16'h0);
         chk("f_stall", 16'(stall_a), 16'h1);
         chk("f_i_ready", 16'(i_ready_a), 16'h0);
      end
      tick();
      chk("f_i_ready4", 16'(i_ready_a), 16'h1);
      chk("f_i_rdata4", i_rdata_a, 16'hABCD);
      chk("f_stall4", 16'(stall_a), 16'h0);
      chk("f_fill_en4", 16'(fill_en_a), 16'h0);
      chk("f_mem_en4", 16'(mem_en_a), 16'h0);
      chk("f_d_ready4", 16'(d_ready_a), 16'h0);
      tick();
      i_req_a = 0;
      #1;
      chk("f_i_ready5", 16'(i_ready_a), 16'h0);
      chk("f_i_rdata_hold", i_rdata_a, 16'hABCD);

      // load miss
      d_req_a = 1; d_we_a = 0; d_addr_a = 16'h0185;
      mem_rdata_a = 16'h1234;
      for (int c = 1; c <= 3; c++) begin
         tick();
         chk("l_mem_en", 16'(mem_en_a), 16'h1);
         chk("l_mem_addr", mem_addr_a, 16'h0185);
         chk("l_d_ready", 16'(d_ready_a), 16'h0);
      end
      tick();
      chk("l_d_ready4", 16'(d_ready_a), 16'h1);
      chk("l_d_rdata", d_rdata_a, 16'h1234);
      chk("l_fill_en", 16'(fill_en_a), 16'h1);
      chk("l_fill_addr", fill_addr_a, 16'h0185);
      chk("l_fill_data", fill_data_a, 16'h1234);
      chk("l_i_ready", 16'(i_ready_a), 16'h0);
      tick();

      // store
      d_we_a = 1; d_addr_a = 16'h0042; d_wdata_a = 16'h5A5A;
      mem_rdata_a = 16'hFFFF;
      for (int c = 1; c <= 3; c++) begin
         tick();
         chk("s_mem_en", 16'(mem_en_a), 16'h1);
         chk("s_mem_we", 16'(mem_we_a), 16'h1);
         chk("s_mem_addr", mem_addr_a, 16'h0042);
         chk("s_mem_wdata", mem_wdata_a, 16'h5A5A);
      end
      tick();
      chk("s_d_ready", 16'(d_ready_a), 16'h1);
      chk("s_d_rdata", d_rdata_a, 16'h5A5A);
      chk("s_fill_en", 16'(fill_en_a), 16'h1);
      chk("s_fill_addr", fill_addr_a, 16'h0042);
      chk("s_fill_data", fill_data_a, 16'h5A5A);
      tick();
      d_req_a = 0; d_we_a = 0;
      chk("s_fill_en5", 16'(fill_en_a), 16'h0);

      // tie held from reset release: D@4 I@9 D@14 I@19
      reset = 1;
      i_req_a = 1; i_addr_a = 16'h0300;
      d_req_a = 1; d_addr_a = 16'h0200;
      mem_rdata_a = 16'h7777;
      tick();
      reset = 0;
      for (int c = 1; c <= 19; c++) begin
         tick();
         chk("t_d_ready", 16'(d_ready_a),
             16'((c == 4) || (c == 14)));
         chk("t_i_ready", 16'(i_ready_a),
             16'((c == 9) || (c == 19)));
         if (c == 1 || c == 11)
            chk("t_mem_addr_d", mem_addr_a, 16'h0200);
         if (c == 6 || c == 16)
            chk("t_mem_addr_i", mem_addr_a, 16'h0300);
         if (c == 4)
            chk("t_stall4", 16'(stall_a), 16'h1);
      end
      tick();
      i_req_a = 0; d_req_a = 0;
      tick();

      // reset during cycle 2 of a load miss
      d_req_a = 1; d_addr_a = 16'h0055; mem_rdata_a = 16'h9999;
      tick();
      tick();
      chk("r_mem_en_c2", 16'(mem_en_a), 16'h1);
      reset = 1;
      #1;
      chk("r_mem_en_drop", 16'(mem_en_a), 16'h0);
      tick();
      chk("r_d_ready", 16'(d_ready_a), 16'h0);
      chk("r_fill_en", 16'(fill_en_a), 16'h0);
      chk("r_mem_en", 16'(mem_en_a), 16'h0);
      reset = 0;
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk("r_mem_en_re", 16'(mem_en_a), 16'(c <= 3));
         chk("r_d_ready_re", 16'(d_ready_a), 16'(c == 4));
      end
      chk("r_d_rdata", d_rdata_a, 16'h9999);
      chk("r_fill_addr", fill_addr_a, 16'h0055);
      tick();
      d_req_a = 0;

      // MEM_LAT=1: fetch at c0, store requested at c3
      i_req_b = 1; i_addr_b = 16'h0020; mem_rdata_b = 16'h0BAD;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 3) begin
            i_req_b = 0;
            d_req_b = 1; d_we_b = 1;
            d_addr_b = 16'h0077; d_wdata_b = 16'h1357;
         end
         chk("b_mem_en", 16'(mem_en_b), 16'((c == 1) || (c == 4)));
         chk("b_i_ready", 16'(i_ready_b), 16'(c == 2));
         chk("b_d_ready", 16'(d_ready_b), 16'(c == 5));
         if (c == 2)
            chk("b_i_rdata", i_rdata_b, 16'h0BAD);
         if (c == 4)
            chk("b_mem_we", 16'(mem_we_b), 16'h1);
         if (c == 5) begin
            chk("b_fill_data", fill_data_b, 16'h1357);
            chk("b_fill_addr", fill_addr_b, 16'h0077);
            d_req_b = 0;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
